// File: rtl/adpll_phase_monitor.sv
// Phase/period monitor for two asynchronous ADPLL outputs sampled on the fabric clock.
// Each A-to-A window reports the A period, the A->B phase offset, a miss flag and a lock indication.
module adpll_phase_monitor #(
  parameter int CNT_WIDTH  = 12,
  parameter int LOCK_TOL   = 4,
  parameter int LOCK_COUNT = 8
) (
  input  logic                 fpga_clk_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic                 sig_a_i,
  input  logic                 sig_b_i,
  output logic [CNT_WIDTH-1:0] period_o,
  output logic [CNT_WIDTH-1:0] phase_o,
  output logic                 valid_o,
  output logic                 miss_o,
  output logic                 locked_o,
  output logic                 timeout_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam int                   RUN_W   = $clog2(LOCK_COUNT + 1);
  localparam logic [RUN_W-1:0]     RUN_MAX = RUN_W'(LOCK_COUNT);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH:0]   TOL_EXT = (CNT_WIDTH + 1)'(LOCK_TOL);

  logic [2:0]           sync_a;
  logic [2:0]           sync_b;
  logic                 ea;
  logic                 eb;
  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic [CNT_WIDTH-1:0] phase_r;
  logic                 pend_r;
  logic [RUN_W-1:0]     run_r;

  logic [CNT_WIDTH-1:0] close_phase;
  logic [CNT_WIDTH:0]   err_fwd;
  logic [CNT_WIDTH:0]   err_rev;
  logic [CNT_WIDTH:0]   err;
  logic                 in_lock;
  logic [RUN_W-1:0]     run_next;

  // Two-flop synchronisers plus one history flop for rising-edge detection.
  // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[1:0], sig_a_i};
      sync_b <= {sync_b[1:0], sig_b_i};
    end
  end

  assign ea = sync_a[1] & ~sync_a[2];
  assign eb = sync_b[1] & ~sync_b[2];

  // Result of the window that closes on this A edge, and its wrapped phase error.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    close_phase = pend_r ? cnt_r : phase_r;
    err_fwd     = {1'b0, close_phase};
    err_rev     = {1'b0, cnt_r} - {1'b0, close_phase};
    err         = (err_fwd < err_rev) ? err_fwd : err_rev;
    in_lock     = !pend_r && (err <= TOL_EXT);
    run_next    = '0;
    if (in_lock) begin
      run_next = (run_r == RUN_MAX) ? RUN_MAX : run_r + RUN_W'(1);
    end
  end

  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      state     <= ST_IDLE;
      cnt_r     <= '0;
      phase_r   <= '0;
      pend_r    <= 1'b0;
      run_r     <= '0;
      period_o  <= '0;
      phase_o   <= '0;
      valid_o   <= 1'b0;
      miss_o    <= 1'b0;
      locked_o  <= 1'b0;
      timeout_o <= 1'b0;
    end else if (!enable_i) begin
      // Disabled: abandon the window but keep the last reported period/phase/miss.
      state     <= ST_IDLE;
      cnt_r     <= '0;
      phase_r   <= '0;
      pend_r    <= 1'b0;
      run_r     <= '0;
      valid_o   <= 1'b0;
      locked_o  <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      valid_o   <= 1'b0;
      timeout_o <= 1'b0;
      case (state)
        ST_IDLE: state <= ST_ARM;
        ST_ARM: begin
          // A B edge coincident with the arming A edge already counts as phase 0.
          if (ea) begin
            cnt_r   <= CNT_WIDTH'(1);
            phase_r <= '0;
            pend_r  <= ~eb;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (ea) begin
            period_o <= cnt_r;
            phase_o  <= close_phase;
            miss_o   <= pend_r;
            valid_o  <= 1'b1;
            run_r    <= run_next;
            locked_o <= (run_next == RUN_MAX);
            cnt_r    <= CNT_WIDTH'(1);
            phase_r  <= '0;
            pend_r   <= ~eb;
          end else if (cnt_r == CNT_MAX) begin
            timeout_o <= 1'b1;
            locked_o  <= 1'b0;
            run_r     <= '0;
            cnt_r     <= '0;
            pend_r    <= 1'b0;
            state     <= ST_ARM;
          end else begin
            cnt_r <= cnt_r + CNT_WIDTH'(1);
            if (eb && pend_r) begin
              phase_r <= cnt_r;
              pend_r  <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adpll_phase_monitor.sv
// Self-checking bench for adpll_phase_monitor: edge-time reference model plus scenario tasks.
module tb_adpll_phase_monitor;

  localparam int CW   = 12;
  localparam int TOL  = 4;
  localparam int LCNT = 8;
  localparam int SAT  = (1 << CW) - 1;
  localparam int PIPE = 3;  // drive-to-output latency in negedge samples

  logic          fpga_clk_i = 1'b0;
  logic          reset_i    = 1'b1;
  logic          enable_i   = 1'b0;
  logic          sig_a_i    = 1'b0;
  logic          sig_b_i    = 1'b0;
  logic [CW-1:0] period_o;
  logic [CW-1:0] phase_o;
  logic          valid_o;
  logic          miss_o;
  logic          locked_o;
  logic          timeout_o;

  adpll_phase_monitor #(.CNT_WIDTH(CW), .LOCK_TOL(TOL), .LOCK_COUNT(LCNT)) dut (
    .fpga_clk_i(fpga_clk_i),
    .reset_i   (reset_i),
    .enable_i  (enable_i),
    .sig_a_i   (sig_a_i),
    .sig_b_i   (sig_b_i),
    .period_o  (period_o),
    .phase_o   (phase_o),
    .valid_o   (valid_o),
    .miss_o    (miss_o),
    .locked_o  (locked_o),
    .timeout_o (timeout_o)
  );

  always #5 fpga_clk_i = ~fpga_clk_i;

  typedef struct packed {
    logic [CW-1:0] period;
    logic [CW-1:0] phase;
    logic          miss;
    logic          valid;
    logic          timeout;
    logic          locked;
  } obs_t;

  obs_t exp_q[$];
  obs_t m;
  int   n_checks;
  int   n_errors;
  int   drv_n;
  bit   drv_en;
  bit   drv_rst;
  bit   prev_a;
  bit   prev_b;
  bit   win_open;
  bit   have_b;
  int   t0;
  int   fb;
  int   run_len;
  int   valid_seen;
  int   timeout_seen;

  // One fabric cycle: compare outputs against the model, then drive and advance the model.
  task automatic step(input bit a, input bit b);
    obs_t e;
    bit   a_rise;
    bit   b_rise;
    int   per;
    int   ph;
    int   err;
    @(negedge fpga_clk_i);
    e = exp_q.pop_front();
    n_checks++;
    if (valid_o !== e.valid || timeout_o !== e.timeout || locked_o !== e.locked ||
        miss_o !== e.miss || period_o !== e.period || phase_o !== e.phase) begin
      n_errors++;
      $display("FAIL cycle %0d outputs: got v=%b t=%b l=%b m=%b per=%0d ph=%0d, want v=%b t=%b l=%b m=%b per=%0d ph=%0d",
               drv_n, valid_o, timeout_o, locked_o, miss_o, period_o, phase_o,
               e.valid, e.timeout, e.locked, e.miss, e.period, e.phase);
    end
    if (valid_o === 1'b1) valid_seen++;
    if (timeout_o === 1'b1) timeout_seen++;

    sig_a_i  = a;
    sig_b_i  = b;
    enable_i = drv_en;
    reset_i  = drv_rst;

    a_rise    = a && !prev_a;
    b_rise    = b && !prev_b;
    prev_a    = a;
    prev_b    = b;
    m.valid   = 1'b0;
    m.timeout = 1'b0;
    if (drv_rst) begin
      m        = '0;
      win_open = 1'b0;
      run_len  = 0;
      foreach (exp_q[i]) exp_q[i] = m;
    end else if (!drv_en) begin
      m.locked = 1'b0;
      win_open = 1'b0;
      run_len  = 0;
      foreach (exp_q[i]) exp_q[i] = m;
    end else if (win_open && a_rise) begin
      per      = drv_n - t0;
      ph       = have_b ? fb : per;
      m.period = per[CW-1:0];
      m.phase  = ph[CW-1:0];
      m.miss   = !have_b;
      m.valid  = 1'b1;
      err      = (ph < per - ph) ? ph : per - ph;
      if (have_b && err <= TOL) run_len = (run_len < LCNT) ? run_len + 1 : LCNT;
      else run_len = 0;
      m.locked = (run_len == LCNT);
      t0       = drv_n;
      have_b   = b_rise;
      fb       = 0;
    end else if (win_open) begin
      if (b_rise && !have_b) begin
        have_b = 1'b1;
        fb     = drv_n - t0;
      end
      if (drv_n - t0 == SAT) begin
        m.timeout = 1'b1;
        m.locked  = 1'b0;
        run_len   = 0;
        win_open  = 1'b0;
      end
    end else if (a_rise) begin
      win_open = 1'b1;
      t0       = drv_n;
      have_b   = b_rise;
      fb       = 0;
    end
    exp_q.push_back(m);
    drv_n++;
  endtask

  // A high for the first half of each window; B pulses (2 cycles) at d1 and d2, negative = none.
  task automatic run_windows(input int n_win, input int period, input int d1, input int d2);
    bit b;
    for (int w = 0; w < n_win; w++) begin
      for (int c = 0; c < period; c++) begin
        b = (d1 >= 0 && (c == d1 || c == d1 + 1)) || (d2 >= 0 && (c == d2 || c == d2 + 1));
        step(c < period / 2, b);
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic restart_enable();
    drv_en = 1'b0;
    idle_cycles(4);
    drv_en = 1'b1;
    idle_cycles(4);
  endtask

  task automatic test_reset();
    drv_rst = 1'b1;
    drv_en  = 1'b0;
    idle_cycles(4);
    n_checks++;
    if ({period_o, phase_o, valid_o, miss_o, locked_o, timeout_o} !== '0) begin
      n_errors++;
      $display("FAIL reset_state: got per=%0d ph=%0d v=%b m=%b l=%b t=%b, want all 0",
               period_o, phase_o, valid_o, miss_o, locked_o, timeout_o);
    end
    drv_rst = 1'b0;
    drv_en  = 1'b1;
    idle_cycles(4);
  endtask

  task automatic test_lock_delay3();
    int v0;
    v0 = valid_seen;
    run_windows(8, 40, 3, -1);
    n_checks++;
    if (locked_o !== 1'b0 || valid_seen - v0 != 7) begin
      n_errors++;
      $display("FAIL lock_before_8th: got locked=%b valids=%0d, want locked=0 valids=7", locked_o, valid_seen - v0);
    end
    run_windows(1, 40, 3, -1);
    n_checks++;
    if (locked_o !== 1'b1 || period_o !== 12'd40 || phase_o !== 12'd3 || miss_o !== 1'b0) begin
      n_errors++;
      $display("FAIL lock_on_8th: got l=%b per=%0d ph=%0d m=%b, want l=1 per=40 ph=3 m=0",
               locked_o, period_o, phase_o, miss_o);
    end
  endtask

  task automatic test_lock_wrap();
    restart_enable();
    run_windows(8, 40, 37, -1);
    n_checks++;
    if (locked_o !== 1'b0) begin
      n_errors++;
      $display("FAIL wrap_before_8th: got locked=%b, want 0", locked_o);
    end
    run_windows(1, 40, 37, -1);
    n_checks++;
    if (locked_o !== 1'b1 || phase_o !== 12'd37) begin
      n_errors++;
      $display("FAIL wrap_lock: got l=%b ph=%0d, want l=1 ph=37", locked_o, phase_o);
    end
    run_windows(2, 40, 10, -1);
    n_checks++;
    if (locked_o !== 1'b0 || phase_o !== 12'd10) begin
      n_errors++;
      $display("FAIL wrap_step_unlock: got l=%b ph=%0d, want l=0 ph=10", locked_o, phase_o);
    end
  endtask

  task automatic test_miss();
    run_windows(6, 40, -1, -1);
    n_checks++;
    if (miss_o !== 1'b1 || phase_o !== 12'd40 || period_o !== 12'd40 || locked_o !== 1'b0) begin
      n_errors++;
      $display("FAIL miss_window: got m=%b ph=%0d per=%0d l=%b, want m=1 ph=40 per=40 l=0",
               miss_o, phase_o, period_o, locked_o);
    end
  endtask

  task automatic test_simultaneous();
    run_windows(8, 40, 0, 20);
    n_checks++;
    if (locked_o !== 1'b0) begin
      n_errors++;
      $display("FAIL simul_before_8th: got locked=%b, want 0", locked_o);
    end
    run_windows(1, 40, 0, 20);
    n_checks++;
    if (locked_o !== 1'b1 || phase_o !== 12'd0 || miss_o !== 1'b0) begin
      n_errors++;
      $display("FAIL simul_lock: got l=%b ph=%0d m=%b, want l=1 ph=0 m=0", locked_o, phase_o, miss_o);
    end
  endtask

  task automatic test_timeout();
    int t_before;
    int v0;
    t_before = timeout_seen;
    idle_cycles(SAT + 10);
    n_checks++;
    if (timeout_seen - t_before != 1 || locked_o !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_pulse: got pulses=%0d locked=%b, want pulses=1 locked=0",
               timeout_seen - t_before, locked_o);
    end
    v0 = valid_seen;
    run_windows(1, 40, 3, -1);
    n_checks++;
    if (valid_seen != v0) begin
      n_errors++;
      $display("FAIL rearm_no_valid: got valids=%0d, want 0", valid_seen - v0);
    end
    run_windows(1, 40, 3, -1);
    n_checks++;
    if (valid_seen - v0 != 1 || period_o !== 12'd40) begin
      n_errors++;
      $display("FAIL rearm_first_valid: got valids=%0d per=%0d, want 1 per=40", valid_seen - v0, period_o);
    end
  endtask

  task automatic partial_window();
    for (int c = 0; c < 25; c++) step(c < 20, c == 3 || c == 4);
  endtask

  task automatic test_reset_mid();
    int v0;
    run_windows(3, 40, 3, -1);
    partial_window();
    drv_rst = 1'b1;
    idle_cycles(4);
    n_checks++;
    if ({period_o, phase_o, valid_o, miss_o, locked_o, timeout_o} !== '0) begin
      n_errors++;
      $display("FAIL reset_mid: got per=%0d ph=%0d v=%b m=%b l=%b t=%b, want all 0",
               period_o, phase_o, valid_o, miss_o, locked_o, timeout_o);
    end
    drv_rst = 1'b0;
    idle_cycles(4);
    v0 = valid_seen;
    run_windows(2, 40, 5, -1);
    n_checks++;
    if (valid_seen - v0 != 1 || phase_o !== 12'd5) begin
      n_errors++;
      $display("FAIL reset_rearm: got valids=%0d ph=%0d, want 1 ph=5", valid_seen - v0, phase_o);
    end
  endtask

  task automatic test_enable_drop();
    int v0;
    run_windows(10, 40, 3, -1);
    partial_window();
    drv_en = 1'b0;
    idle_cycles(5);
    v0 = valid_seen;
    run_windows(2, 32, 7, -1);
    n_checks++;
    if (valid_seen != v0 || locked_o !== 1'b0 || period_o !== 12'd40 || phase_o !== 12'd3) begin
      n_errors++;
      $display("FAIL enable_low_hold: got valids=%0d l=%b per=%0d ph=%0d, want 0 l=0 per=40 ph=3",
               valid_seen - v0, locked_o, period_o, phase_o);
    end
    drv_en = 1'b1;
    idle_cycles(2);
    run_windows(1, 32, 7, -1);
    n_checks++;
    if (valid_seen != v0) begin
      n_errors++;
      $display("FAIL reenable_arm_only: got valids=%0d, want 0", valid_seen - v0);
    end
    run_windows(1, 32, 7, -1);
    n_checks++;
    if (valid_seen - v0 != 1 || period_o !== 12'd32 || phase_o !== 12'd7) begin
      n_errors++;
      $display("FAIL reenable_first_valid: got valids=%0d per=%0d ph=%0d, want 1 per=32 ph=7",
               valid_seen - v0, period_o, phase_o);
    end
  endtask

  task automatic test_random();
    int per;
    int d1;
    int d2;
    int nw;
    int e0;
    e0 = n_errors;
    for (int s = 0; s < 12; s++) begin
      per = $urandom_range(120, 16);
      nw  = $urandom_range(12, 3);
      d1  = ($urandom_range(4, 0) == 0) ? -1 : $urandom_range(per - 3, 0);
      d2  = -1;
      if (d1 >= 0 && d1 + 3 <= per - 3 && $urandom_range(1, 0) == 1) d2 = $urandom_range(per - 3, d1 + 3);
      if ($urandom_range(3, 0) == 0) d1 = $urandom_range(TOL, 0);
      run_windows(nw, per, d1, d2);
    end
    n_checks++;
    if (n_errors != e0) begin
      $display("FAIL random_segments: %0d cycle errors during random windows, want 0", n_errors - e0);
    end
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    drv_n        = 0;
    drv_en       = 1'b0;
    drv_rst      = 1'b1;
    m            = '0;
    win_open     = 1'b0;
    run_len      = 0;
    valid_seen   = 0;
    timeout_seen = 0;
    for (int i = 0; i < PIPE; i++) exp_q.push_back('0);

    test_reset();
    test_lock_delay3();
    test_lock_wrap();
    test_miss();
    test_simultaneous();
    test_timeout();
    test_reset_mid();
    test_enable_drop();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
